// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 2-to-4 decoder: steps codes 0..3 with a programmable dwell and en=0 gaps.
// Optional build macro SCAN_MASK_EN adds a per-step skip mask.
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int GAP     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               continuous_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef SCAN_MASK_EN
    input  logic [3:0]         mask_i,
`endif
    output logic               en_o,
    output logic               w1_o,
    output logic               w0_o,
    output logic               busy_o,
    output logic               step_pulse_o,
    output logic               frame_done_o
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         step_q, step_d;
    logic [1:0]         next_step_q, next_step_d;
    logic               go_idle_q, go_idle_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [3:0]         mask_q, mask_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               sp_q, sp_d;
    logic               fd_q, fd_d;

    logic [3:0]         mask_src;
    logic [DWELL_W-1:0] dwell_eff;
    logic [2:0]         first_src;
    logic [2:0]         nxt_q;

`ifdef SCAN_MASK_EN
    assign mask_src = mask_i;
`else
    assign mask_src = 4'b0000;
`endif

    // Returns {found, index} of the first unmasked step at or after 'from'.
    function automatic logic [2:0] next_unmasked(input logic [3:0] mask, input logic [2:0] from);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!found && (3'(k) >= from) && !mask[k]) begin
                found = 1'b1;
                idx   = 2'(k);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic last_step(input logic [3:0] mask, input logic [1:0] s);
        logic [2:0] r;
        r = next_unmasked(mask, {1'b0, s} + 3'd1);
        return !r[2];
    endfunction

    assign dwell_eff = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    assign first_src = next_unmasked(mask_src, 3'd0);
    assign nxt_q     = next_unmasked(mask_q, {1'b0, step_q} + 3'd1);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        next_step_d = next_step_q;
        go_idle_d   = go_idle_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        gap_d       = gap_q;
        mask_d      = mask_q;
        en_d        = en_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i && first_src[2]) begin
                    state_d = S_ACTIVE;
                    step_d  = first_src[1:0];
                    dwell_d = dwell_eff;
                    mask_d  = mask_src;
                    cnt_d   = dwell_eff;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cnt_q != DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    // Pick what follows this step; the last step may wrap with a fresh mask.
                    if (nxt_q[2]) begin
                        next_step_d = nxt_q[1:0];
                        go_idle_d   = 1'b0;
                    end else if (continuous_i && first_src[2]) begin
                        next_step_d = first_src[1:0];
                        mask_d      = mask_src;
                        go_idle_d   = 1'b0;
                    end else begin
                        next_step_d = 2'd0;
                        go_idle_d   = 1'b1;
                    end

                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP);
                        en_d    = 1'b0;
                    end else if (go_idle_d) begin
                        state_d = S_IDLE;
                        step_d  = 2'd0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        step_d = next_step_d;
                        cnt_d  = dwell_q;
                    end
                end
            end
            S_GAP: begin
                if (gap_q != GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (go_idle_q) begin
                    state_d = S_IDLE;
                    step_d  = 2'd0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_ACTIVE;
                    step_d  = next_step_q;
                    cnt_d   = dwell_q;
                    en_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 2'd0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        sp_d = (state_d == S_ACTIVE) && (cnt_d == DWELL_W'(1));
        fd_d = sp_d && last_step(mask_d, step_d);

        // Abort wins over every other event in the same cycle.
        if (stop_i) begin
            state_d = S_IDLE;
            step_d  = 2'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            sp_d    = 1'b0;
            fd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            next_step_q <= 2'd0;
            go_idle_q   <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            gap_q       <= '0;
            mask_q      <= 4'b0000;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            sp_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            next_step_q <= next_step_d;
            go_idle_q   <= go_idle_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            gap_q       <= gap_d;
            mask_q      <= mask_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            sp_q        <= sp_d;
            fd_q        <= fd_d;
        end
    end

    assign en_o         = en_q;
    assign w1_o         = step_q[1];
    assign w0_o         = step_q[0];
    assign busy_o       = busy_q;
    assign step_pulse_o = sp_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer (DWELL_W=8, GAP=1); output vector is {busy,en,w1,w0,step_pulse,frame_done}.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] dwell = 8'd0;
`ifdef SCAN_MASK_EN
    logic [3:0] mask = 4'b0000;
`endif
    logic       en, w1, w0, busy, step_pulse, frame_done;

    int compared = 0;
    int mismatched = 0;

    decoder_scan_sequencer #(.DWELL_W(8), .GAP(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .continuous_i (continuous),
        .dwell_i      (dwell),
`ifdef SCAN_MASK_EN
        .mask_i       (mask),
`endif
        .en_o         (en),
        .w1_o         (w1),
        .w0_o         (w0),
        .busy_o       (busy),
        .step_pulse_o (step_pulse),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] v(input logic b, input logic e, input logic [1:0] w,
                                     input logic s, input logic f);
        return {b, e, w, s, f};
    endfunction

    task automatic chk(input string tag, input logic [5:0] expv);
        logic [5:0] obs;
        obs = {busy, en, w1, w0, step_pulse, frame_done};
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset and idle
        #1;
        chk("reset", 6'b0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), 6'b0);
        end

        // One-shot, dwell=3
        dwell = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("oneshot_k%0d_j%0d", k, j),
                    v(1'b1, 1'b1, 2'(k), j == 2, (j == 2) && (k == 3)));
                tick();
            end
            chk($sformatf("oneshot_gap%0d", k), v(1'b1, 1'b0, 2'(k), 1'b0, 1'b0));
            tick();
        end
        chk("oneshot_done", 6'b0);
        tick();
        chk("oneshot_stay_idle", 6'b0);

        // Continuous, dwell=2: two full frames then a stop
        dwell = 8'd2;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cont_f%0d_k%0d_a", f, k), v(1'b1, 1'b1, 2'(k), 1'b0, 1'b0));
                tick();
                chk($sformatf("cont_f%0d_k%0d_b", f, k), v(1'b1, 1'b1, 2'(k), 1'b1, k == 3));
                tick();
                chk($sformatf("cont_f%0d_k%0d_g", f, k), v(1'b1, 1'b0, 2'(k), 1'b0, 1'b0));
                tick();
            end
        end
        chk("cont_wrap3", v(1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        continuous = 1'b0;
        chk("cont_stop", 6'b0);

        // Stop together with start during step 2
        dwell = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("stop_pre", v(1'b1, 1'b1, 2'd2, 1'b0, 1'b0));
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        chk("stop_idle", 6'b0);
        tick();
        chk("stop_idle2", 6'b0);

        // dwell=0 behaves as 1
        dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dw0_k%0d", k), v(1'b1, 1'b1, 2'(k), 1'b1, k == 3));
            tick();
            chk($sformatf("dw0_gap%0d", k), v(1'b1, 1'b0, 2'(k), 1'b0, 1'b0));
            tick();
        end
        chk("dw0_done", 6'b0);

        // dwell=255 with a second start mid-frame
        dwell = 8'd255;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("dw255_c1", v(1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        repeat (4) tick();
        dwell = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("dw255_c6", v(1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        repeat (248) tick();
        chk("dw255_c254", v(1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        tick();
        chk("dw255_c255", v(1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        tick();
        chk("dw255_gap", v(1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        tick();
        chk("dw255_step1", v(1'b1, 1'b1, 2'd1, 1'b0, 1'b0));
        tick();
        chk("dw255_step1_held", v(1'b1, 1'b1, 2'd1, 1'b0, 1'b0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("dw255_stop", 6'b0);

        // Asynchronous reset mid-frame clears outputs without a clock edge
        dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arst_pre", v(1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        tick();
        tick();
        chk("arst_pre2", v(1'b1, 1'b1, 2'd1, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_now", 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_after", 6'b0);

`ifdef SCAN_MASK_EN
        // Masked steps are skipped
        mask = 4'b0101;
        dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mask_s1", v(1'b1, 1'b1, 2'd1, 1'b1, 1'b0));
        tick();
        chk("mask_g1", v(1'b1, 1'b0, 2'd1, 1'b0, 1'b0));
        tick();
        chk("mask_s3", v(1'b1, 1'b1, 2'd3, 1'b1, 1'b1));
        tick();
        chk("mask_g3", v(1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        tick();
        chk("mask_done", 6'b0);
        mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mask_all", 6'b0);
        tick();
        chk("mask_all2", 6'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
